// File: rtl/regfile_access_sequencer.sv
// Purpose : arbitrates the single-port 8x16 register file between operand fetch and writeback.
// Latency : write ack 1 cycle after accept; operands valid 4 (two-op) / 3 (one-op) cycles after accept.
// Backpress: fetch_ready low while busy or while a write is pending; wb_req held until wb_ack.
module regfile_access_sequencer #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  fetch_req,
  input  logic [ADDR_WIDTH-1:0] fetch_ra,
  input  logic [ADDR_WIDTH-1:0] fetch_rb,
  input  logic                  fetch_nb,
  output logic                  fetch_ready,
  output logic                  operand_valid,
  output logic [DATA_WIDTH-1:0] operand_a,
  output logic [DATA_WIDTH-1:0] operand_b,
  input  logic                  wb_req,
  input  logic [ADDR_WIDTH-1:0] wb_addr,
  input  logic [DATA_WIDTH-1:0] wb_value,
  output logic                  wb_ack,
  output logic [ADDR_WIDTH-1:0] rf_address,
  output logic                  rf_readflag,
  output logic [DATA_WIDTH-1:0] rf_value,
  input  logic [DATA_WIDTH-1:0] rf_readout
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WR    = 3'd1,
    S_RD_A  = 3'd2,
    S_RD_B  = 3'd3,
    S_CAP_A = 3'd4,
    S_CAP_B = 3'd5
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;

  logic [ADDR_WIDTH-1:0] r_wb_addr;
  logic [DATA_WIDTH-1:0] r_wb_value;
  logic [ADDR_WIDTH-1:0] r_ra;
  logic [ADDR_WIDTH-1:0] r_rb;
  logic                  r_nb;

  logic                  r_operand_valid;
  logic [DATA_WIDTH-1:0] r_operand_a;
  logic [DATA_WIDTH-1:0] r_operand_b;

  logic                  w_fetch_ready;
  logic                  w_wb_ack;
  logic [ADDR_WIDTH-1:0] w_rf_address;
  logic                  w_rf_readflag;
  logic [DATA_WIDTH-1:0] w_rf_value;

  // State register; reset abandons any in-flight write or fetch.
  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Request fields are sampled only at acceptance in IDLE; later input changes are ignored.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wb_addr  <= '0;
      r_wb_value <= '0;
      r_ra       <= '0;
      r_rb       <= '0;
      r_nb       <= 1'b0;
    end else if (r_state == S_IDLE) begin
      if (wb_req) begin
        r_wb_addr  <= wb_addr;
        r_wb_value <= wb_value;
      end else if (fetch_req) begin
        r_ra <= fetch_ra;
        r_rb <= fetch_rb;
        r_nb <= fetch_nb;
      end
    end
  end

  // Operand capture: readout lags the issued read address by one cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_operand_valid <= 1'b0;
      r_operand_a     <= '0;
      r_operand_b     <= '0;
    end else begin
      r_operand_valid <= 1'b0;
      case (r_state)
        S_RD_B: begin
          r_operand_a <= rf_readout;
        end
        S_CAP_A: begin
          r_operand_a     <= rf_readout;
          r_operand_b     <= '0;
          r_operand_valid <= 1'b1;
        end
        S_CAP_B: begin
          r_operand_b     <= rf_readout;
          r_operand_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Next state and register-file port drive; reset forces a read so no write can slip through.
  always_comb begin
    w_state_nxt   = r_state;
    w_fetch_ready = 1'b0;
    w_wb_ack      = 1'b0;
    w_rf_address  = '0;
    w_rf_readflag = 1'b1;
    w_rf_value    = '0;
    case (r_state)
      S_IDLE: begin
        w_fetch_ready = !wb_req;
        if (wb_req)         w_state_nxt = S_WR;
        else if (fetch_req) w_state_nxt = S_RD_A;
      end
      S_WR: begin
        w_rf_readflag = 1'b0;
        w_rf_address  = r_wb_addr;
        w_rf_value    = r_wb_value;
        w_wb_ack      = 1'b1;
        w_state_nxt   = S_IDLE;
      end
      S_RD_A: begin
        w_rf_address = r_ra;
        w_state_nxt  = r_nb ? S_CAP_A : S_RD_B;
      end
      S_RD_B: begin
        w_rf_address = r_rb;
        w_state_nxt  = S_CAP_B;
      end
      S_CAP_A: w_state_nxt = S_IDLE;
      S_CAP_B: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (reset) begin
      w_fetch_ready = 1'b0;
      w_wb_ack      = 1'b0;
      w_rf_address  = '0;
      w_rf_readflag = 1'b1;
      w_rf_value    = '0;
    end
  end

  assign fetch_ready   = w_fetch_ready;
  assign wb_ack        = w_wb_ack;
  assign rf_address    = w_rf_address;
  assign rf_readflag   = w_rf_readflag;
  assign rf_value      = w_rf_value;
  assign operand_valid = r_operand_valid;
  assign operand_a     = r_operand_a;
  assign operand_b     = r_operand_b;

endmodule
